// File: rtl/des_sched_pkg.sv
// Shared types and width helpers for the des_block scheduler.
package des_sched_pkg;

   typedef enum logic [1:0] {
      SlotIdle    = 2'd0,
      SlotRunning = 2'd1,
      SlotHeld    = 2'd2,
      SlotClear   = 2'd3
   } slot_state_e;

   // Index width for NUM_BLOCKS slots, never narrower than one bit.
   function automatic int unsigned calc_idx_w(input int unsigned num_blocks);
      return (num_blocks <= 1) ? 1 : $clog2(num_blocks);
   endfunction

   function automatic int unsigned calc_cnt_w(input int unsigned n);
      return 64 - n;
   endfunction

endpackage

// File: rtl/des_sched_prio_enc.sv
// Lowest-index-set priority encoder: index of the lowest set request bit plus a found flag.
module des_sched_prio_enc #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [WIDTH-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/des_block_scheduler.sv
// Job dispatcher / result collector for an array of des_block instances.
// Optional per-slot cycle counters and res_cycles output: define DES_SCHED_CYCLES_EN.
module des_block_scheduler
   import des_sched_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 4,
   parameter int unsigned N          = 32,
   parameter int unsigned TAG_W      = 8,
   localparam int unsigned IDX_W     = calc_idx_w(NUM_BLOCKS),
   localparam int unsigned CNT_W     = calc_cnt_w(N)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [63:0]                 cmd_seed,
   input  logic [63:0]                 cmd_polynomial,
   input  logic [TAG_W-1:0]            cmd_tag,
   output logic [NUM_BLOCKS-1:0]       blk_start,
   output logic [NUM_BLOCKS-1:0]       blk_restart,
   output logic [63:0]                 blk_seed,
   output logic [63:0]                 blk_polynomial,
   input  logic [NUM_BLOCKS-1:0]       blk_done,
   input  logic [NUM_BLOCKS*CNT_W-1:0] blk_counter,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [CNT_W-1:0]            res_counter,
   output logic [IDX_W-1:0]            res_index,
   output logic [TAG_W-1:0]            res_tag,
   output logic                        busy
`ifdef DES_SCHED_CYCLES_EN
   ,
   output logic [31:0]                 res_cycles
`endif
);

   slot_state_e               slot_q [NUM_BLOCKS];
   slot_state_e               slot_d [NUM_BLOCKS];
   logic [TAG_W-1:0]          tag_q  [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0]     idle_vec, done_vec, start_q, restart_q;
   logic [63:0]               seed_q, poly_q;
   logic                      res_valid_q;
   logic [CNT_W-1:0]          res_counter_q;
   logic [IDX_W-1:0]          res_index_q, disp_idx, coll_idx;
   logic [TAG_W-1:0]          res_tag_q;
   logic                      disp_found, coll_found;
   logic                      dispatch, capture, handshake;

   always_comb begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         idle_vec[i] = (slot_q[i] == SlotIdle);
         // A slot in its start cycle cannot be collected, so start and capture never coincide.
         done_vec[i] = (slot_q[i] == SlotRunning) && blk_done[i] && !start_q[i];
      end
   end

   des_sched_prio_enc #(.WIDTH(NUM_BLOCKS), .IDX_W(IDX_W)) u_disp_enc (
      .req   (idle_vec),
      .idx   (disp_idx),
      .found (disp_found)
   );

   des_sched_prio_enc #(.WIDTH(NUM_BLOCKS), .IDX_W(IDX_W)) u_coll_enc (
      .req   (done_vec),
      .idx   (coll_idx),
      .found (coll_found)
   );

   assign cmd_ready = disp_found;
   assign dispatch  = cmd_valid && disp_found;
   assign handshake = res_valid_q && res_ready;
   assign capture   = coll_found && (!res_valid_q || res_ready);

   always_comb begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         slot_d[i] = slot_q[i];
         if (slot_q[i] == SlotClear) slot_d[i] = SlotIdle;
         if (handshake && res_index_q == IDX_W'(i)) slot_d[i] = SlotClear;
         if (capture && coll_idx == IDX_W'(i)) slot_d[i] = SlotHeld;
         if (dispatch && disp_idx == IDX_W'(i)) slot_d[i] = SlotRunning;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            slot_q[i] <= SlotIdle;
            tag_q[i]  <= '0;
         end
         start_q       <= '0;
         restart_q     <= '0;
         seed_q        <= '0;
         poly_q        <= '0;
         res_valid_q   <= 1'b0;
         res_counter_q <= '0;
         res_index_q   <= '0;
         res_tag_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_BLOCKS; i++) slot_q[i] <= slot_d[i];
         start_q   <= dispatch ? (NUM_BLOCKS'(1) << disp_idx) : '0;
         restart_q <= handshake ? (NUM_BLOCKS'(1) << res_index_q) : '0;
         if (dispatch) begin
            seed_q          <= cmd_seed;
            poly_q          <= cmd_polynomial;
            tag_q[disp_idx] <= cmd_tag;
         end
         if (capture) begin
            res_valid_q   <= 1'b1;
            res_counter_q <= blk_counter[coll_idx*CNT_W +: CNT_W];
            res_index_q   <= coll_idx;
            res_tag_q     <= tag_q[coll_idx];
         end else if (handshake) begin
            res_valid_q <= 1'b0;
         end
      end
   end

`ifdef DES_SCHED_CYCLES_EN
   logic [31:0] cyc_q [NUM_BLOCKS];
   logic [31:0] cyc_d [NUM_BLOCKS];
   logic [31:0] res_cycles_q;

   // The captured value includes the capture cycle itself.
   always_comb begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         cyc_d[i] = cyc_q[i];
         if (slot_q[i] == SlotRunning && cyc_q[i] != 32'hFFFF_FFFF) cyc_d[i] = cyc_q[i] + 32'd1;
         if (dispatch && disp_idx == IDX_W'(i)) cyc_d[i] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BLOCKS; i++) cyc_q[i] <= '0;
         res_cycles_q <= '0;
      end else begin
         for (int i = 0; i < NUM_BLOCKS; i++) cyc_q[i] <= cyc_d[i];
         if (capture) res_cycles_q <= cyc_d[coll_idx];
      end
   end

   assign res_cycles = res_cycles_q;
`endif

   assign blk_start      = start_q;
   assign blk_restart    = restart_q;
   assign blk_seed       = seed_q;
   assign blk_polynomial = poly_q;
   assign res_valid      = res_valid_q;
   assign res_counter    = res_counter_q;
   assign res_index      = res_index_q;
   assign res_tag        = res_tag_q;
   assign busy           = ~&idle_vec;

endmodule

// File: tb/tb_des_block_scheduler.sv
// Directed self-checking bench for des_block_scheduler; the block array is driven by hand.
module tb_des_block_scheduler;

   localparam int unsigned NB = 4;
   localparam int unsigned CW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [63:0]     cmd_seed, cmd_polynomial;
   logic [7:0]      cmd_tag;
   logic [NB-1:0]   blk_start, blk_restart, blk_done;
   logic [63:0]     blk_seed, blk_polynomial;
   logic [NB*CW-1:0] blk_counter;
   logic            res_valid, res_ready, busy;
   logic [CW-1:0]   res_counter;
   logic [1:0]      res_index;
   logic [7:0]      res_tag;
`ifdef DES_SCHED_CYCLES_EN
   logic [31:0]     res_cycles;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   des_block_scheduler #(.NUM_BLOCKS(NB), .N(32), .TAG_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_seed       (cmd_seed),
      .cmd_polynomial (cmd_polynomial),
      .cmd_tag        (cmd_tag),
      .blk_start      (blk_start),
      .blk_restart    (blk_restart),
      .blk_seed       (blk_seed),
      .blk_polynomial (blk_polynomial),
      .blk_done       (blk_done),
      .blk_counter    (blk_counter),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_counter    (res_counter),
      .res_index      (res_index),
      .res_tag        (res_tag),
      .busy           (busy)
`ifdef DES_SCHED_CYCLES_EN
      ,
      .res_cycles     (res_cycles)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] tag, input logic [63:0] seed, input logic [63:0] poly);
      cmd_valid      = 1'b1;
      cmd_tag        = tag;
      cmd_seed       = seed;
      cmd_polynomial = poly;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_seed = '0; cmd_polynomial = '0; cmd_tag = '0;
      blk_done = '0; blk_counter = '0; res_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_start", blk_start, 0);
      chk("rst_restart", blk_restart, 0);
      chk("rst_seed", blk_seed, 0);

      // Basic job
      send(8'h5A, 64'h1, 64'h1B);
      tick();
      cmd_valid = 1'b0;
      chk("basic_start", blk_start, 4'b0001);
      chk("basic_seed", blk_seed, 64'h1);
      chk("basic_poly", blk_polynomial, 64'h1B);
      chk("basic_busy", busy, 1);
      tick();
      chk("basic_start_off", blk_start, 0);
      repeat (98) tick();
      blk_counter[0 +: CW] = 32'h0000_1234;
      blk_done[0] = 1'b1;
      res_ready = 1'b1;
      tick();
      chk("basic_valid", res_valid, 1);
      chk("basic_counter", res_counter, 32'h1234);
      chk("basic_index", res_index, 0);
      chk("basic_tag", res_tag, 8'h5A);
      tick();
      chk("basic_hs_valid", res_valid, 0);
      chk("basic_restart", blk_restart, 4'b0001);
      chk("basic_clear_busy", busy, 1);
      tick();
      blk_done[0] = 1'b0;
      chk("basic_restart_off", blk_restart, 0);
      chk("basic_idle_busy", busy, 0);
      chk("basic_stale_done", res_valid, 0);

      // Full occupancy
      res_ready = 1'b0;
      send(8'h10, 64'h100, 64'h200);
      tick();
      chk("full_start0", blk_start, 4'b0001);
      send(8'h11, 64'h101, 64'h200);
      tick();
      chk("full_start1", blk_start, 4'b0010);
      send(8'h12, 64'h102, 64'h200);
      tick();
      chk("full_start2", blk_start, 4'b0100);
      send(8'h13, 64'h103, 64'h200);
      tick();
      chk("full_start3", blk_start, 4'b1000);
      chk("full_ready0", cmd_ready, 0);
      send(8'h14, 64'h104, 64'h300);
      tick();
      chk("full_blocked_start", blk_start, 0);
      chk("full_blocked_seed", blk_seed, 64'h103);
      blk_counter[2*CW +: CW] = 32'h0000_AAAA;
      blk_done[2] = 1'b1;
      res_ready = 1'b1;
      tick();
      chk("full_cap_index", res_index, 2);
      chk("full_cap_tag", res_tag, 8'h12);
      chk("full_cap_counter", res_counter, 32'hAAAA);
      chk("full_held_ready", cmd_ready, 0);
      tick();
      chk("full_restart", blk_restart, 4'b0100);
      chk("full_clear_ready", cmd_ready, 0);
      tick();
      blk_done[2] = 1'b0;
      chk("full_free_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("full_fifth_start", blk_start, 4'b0100);
      chk("full_fifth_seed", blk_seed, 64'h104);
      chk("full_fifth_poly", blk_polynomial, 64'h300);

      // Collection order: done on slots 3 and 1 together
      blk_counter[1*CW +: CW] = 32'h0000_1111;
      blk_counter[3*CW +: CW] = 32'h0000_3333;
      blk_done[1] = 1'b1;
      blk_done[3] = 1'b1;
      tick();
      chk("order_first_valid", res_valid, 1);
      chk("order_first_index", res_index, 1);
      chk("order_first_counter", res_counter, 32'h1111);
      chk("order_first_tag", res_tag, 8'h11);
      tick();
      blk_done[1] = 1'b0;
      chk("order_second_valid", res_valid, 1);
      chk("order_second_index", res_index, 3);
      chk("order_second_counter", res_counter, 32'h3333);
      chk("order_second_tag", res_tag, 8'h13);
      chk("order_restart1", blk_restart, 4'b0010);
      tick();
      blk_done[3] = 1'b0;
      chk("order_done_valid", res_valid, 0);
      chk("order_restart3", blk_restart, 4'b1000);
      tick();
      chk("order_restart_off", blk_restart, 0);

      // Backpressure: slots 0 and 2 finish, host stalls
      res_ready = 1'b0;
      blk_counter[0 +: CW]    = 32'h0000_C0C0;
      blk_counter[2*CW +: CW] = 32'h0000_C2C2;
      blk_done[0] = 1'b1;
      blk_done[2] = 1'b1;
      tick();
      chk("bp_first_tag", res_tag, 8'h10);
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("bp_valid", res_valid, 1);
         chk("bp_index", res_index, 0);
         chk("bp_counter", res_counter, 32'hC0C0);
         chk("bp_restart", blk_restart, 0);
      end
      res_ready = 1'b1;
      tick();
      blk_done[0] = 1'b0;
      res_ready = 1'b0;
      chk("bp_second_valid", res_valid, 1);
      chk("bp_second_index", res_index, 2);
      chk("bp_second_counter", res_counter, 32'hC2C2);
      chk("bp_second_tag", res_tag, 8'h14);
      chk("bp_restart0", blk_restart, 4'b0001);
      tick();
      chk("bp_hold_index", res_index, 2);
      tick();

      // Reset with slot 2 HELD and slots 0,1 RUNNING
      send(8'h20, 64'h400, 64'h500);
      tick();
      chk("rm_start0", blk_start, 4'b0001);
      send(8'h21, 64'h401, 64'h500);
      tick();
      cmd_valid = 1'b0;
      chk("rm_start1", blk_start, 4'b0010);
      rst_n = 1'b0;
      #1;
      chk("rm_res_valid", res_valid, 0);
      chk("rm_start", blk_start, 0);
      chk("rm_restart", blk_restart, 0);
      chk("rm_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rm_cmd_ready", cmd_ready, 1);
      chk("rm_busy_after", busy, 0);
      tick();
      chk("rm_unstarted_done", res_valid, 0);
      blk_done = '0;
      tick();

`ifdef DES_SCHED_CYCLES_EN
      // Done after exactly 200 cycles RUNNING
      send(8'h33, 64'h7, 64'h9);
      tick();
      cmd_valid = 1'b0;
      chk("cyc_start", blk_start, 4'b0001);
      repeat (199) tick();
      blk_counter[0 +: CW] = 32'h0000_0042;
      blk_done[0] = 1'b1;
      tick();
      chk("cyc_valid", res_valid, 1);
      chk("cyc_tag", res_tag, 8'h33);
      chk("cyc_cycles", res_cycles, 32'd200);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/des_block_scheduler.md
Name: des_block_scheduler

Overview:
- Job dispatcher and result collector that sits above an array of NUM_BLOCKS des_block instances.
- Accepts cryptanalysis jobs (seed, polynomial, tag) from a host stream and starts each one on a free block.
- Watches each block's done, captures its counter, streams the result out with a valid/ready handshake, then restarts the block so it can be reused.

Parameters:
- NUM_BLOCKS, 4, number of attached des_block instances (1..16).
- N, 32, region-select bits; counter width is 64-N, matching des_block.
- TAG_W, 8, width of the host job tag echoed with each result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active low.
- cmd_valid  in  1  host job request.
- cmd_ready  out  1  job accepted on the cycle both are high.
- cmd_seed  in  64  LFSR seed for the job.
- cmd_polynomial  in  64  LFSR polynomial for the job.
- cmd_tag  in  TAG_W  host tag for the job.
- blk_start  out  NUM_BLOCKS  one-cycle start pulse per block.
- blk_restart  out  NUM_BLOCKS  one-cycle restart_block pulse per block.
- blk_seed  out  64  shared seed bus to all blocks.
- blk_polynomial  out  64  shared polynomial bus to all blocks.
- blk_done  in  NUM_BLOCKS  done level from each block.
- blk_counter  in  NUM_BLOCKS*(64-N)  concatenated counters; block i occupies bits [i*(64-N) +: 64-N].
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- res_counter  out  64-N  captured counter value.
- res_index  out  IDX_W  index of the block that produced the result.
- res_tag  out  TAG_W  tag of the job.
- busy  out  1  at least one slot is not IDLE.

Behaviour:
- Per-slot state: IDLE, RUNNING, HELD, CLEAR. All slots reset to IDLE.
- Reset values: all outputs 0, except cmd_ready, which is 1 as soon as reset deasserts.
- cmd_ready (combinational) = at least one slot IDLE.
- Dispatch, on an edge where cmd_valid and cmd_ready are both high:
  - Pick i = lowest-index IDLE slot.
  - Register seed and polynomial onto the shared buses, store the tag in tag[i], and set blk_start[i] high for exactly the next cycle.
  - Slot i goes to RUNNING.
- The shared buses hold their value until the next dispatch. A new job may be accepted on the very next edge, giving a throughput of one job per cycle; block i samples the bus on the edge that ends its start pulse.
- Collection:
  - Capture is allowed when res_valid is 0, or when res_valid and res_ready are both high.
  - On such an edge, pick j = lowest-index slot that is RUNNING with blk_done[j] high.
  - Load res_counter, res_index = j and res_tag = tag[j]; set res_valid = 1; slot j goes to HELD.
  - blk_start for the same slot is never high in that same cycle.
- Output handshake: res_valid and all res_* fields hold stable until res_ready is high.
- On the handshake edge for slot k:
  - blk_restart[k] is high for the next cycle and slot k goes to CLEAR.
  - If no new capture happens, res_valid drops.
  - A capture on the same edge (a different slot) keeps res_valid at 1, back-to-back.
- CLEAR lasts exactly one cycle, then the slot goes to IDLE. This guarantees that restart and start never overlap, and that a stale done (which persists until the restart edge) is never recaptured.
- A slot in IDLE, CLEAR or HELD ignores blk_done.
- blk_done high on a slot that was never started: ignored; no result is produced.
- Simultaneous dispatch and capture on different slots are both performed in the same cycle.
- Reset mid-operation: all slots go to IDLE; pending results and tags are discarded; the attached blocks share rst_n.
- busy = OR of slot states not equal to IDLE.

Optional Feature:
- Macro DES_SCHED_CYCLES_EN.
- When defined:
  - Each slot has a 32-bit cycle counter, cleared on dispatch and incremented every cycle while RUNNING, saturating at 0xFFFF_FFFF.
  - The counter value is captured alongside the result on the extra output res_cycles [31:0], which is 0 at reset.
- When undefined: no res_cycles port and no counters.

Decomposition:
- Package des_sched_pkg holds:
  - the slot-state enum (2 bits);
  - IDX_W = clog2(NUM_BLOCKS), minimum 1;
  - CNT_W = 64-N.
- One sub-module, des_sched_prio_enc: a parameterized lowest-index-set priority encoder returning index and found flag. It is instantiated twice, once for the dispatch pick and once for the collection pick.

Test Plan:
- Basic job: reset, one cmd (seed 0x1, poly 0x1B, tag 0x5A); force blk_done[0] with counter 0x00001234 after 100 cycles, res_ready=1. Expect:
  - blk_start[0] high for one cycle;
  - res_valid with res_counter=0x1234, res_index=0, res_tag=0x5A;
  - blk_restart[0] one cycle after the handshake;
  - slot 0 IDLE two edges after the handshake.
- Full occupancy: four cmds on consecutive cycles. Expect:
  - blk_start pulses to slots 0,1,2,3 on successive cycles;
  - the fifth cmd_valid sees cmd_ready=0 until one of the first four jobs has been collected and its slot cleared.
- Collection order: blk_done[3] and blk_done[1] rise together, res_ready=1. Expect the index 1 result, then the index 3 result on the next cycle (res_valid held at 1 across both), with the matching restarts.
- Backpressure: res_ready=0 for 50 cycles with a result pending and a second done present. Expect:
  - res fields stable;
  - no restart, and the second block stays RUNNING;
  - after res_ready rises, the second result appears the following cycle.
- Reset mid-operation: rst_n low while two slots are RUNNING and one is HELD. Expect res_valid=0, blk_start=0 and blk_restart=0 immediately; after release cmd_ready=1 and busy=0.
- With DES_SCHED_CYCLES_EN: start a job and assert done after exactly 200 cycles RUNNING. Expect res_cycles=200.
